// File: rtl/maze_pkg.sv
// Shared constants for the maze display scan-out: 848x480@60 timing, palette,
// map line width and the marker window test.
package maze_pkg;

  localparam int H_ACTIVE = 848;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 112;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 6;
  localparam int V_SYNC   = 8;
  localparam int V_BP     = 23;

  localparam int MARK     = 8;
  localparam int LINE_W   = 2 * H_ACTIVE;

  localparam logic [23:0] COL_BLANK  = 24'h000000;
  localparam logic [23:0] COL_WALL   = 24'h0000FF;
  localparam logic [23:0] COL_FLOOR  = 24'h000000;
  localparam logic [23:0] COL_WIN    = 24'hFFFFFF;
  localparam logic [23:0] COL_PLAYER = 24'h00FF00;
  localparam logic [23:0] COL_ANT1   = 24'hFF0000;
  localparam logic [23:0] COL_ANT2   = 24'hFF8000;

  // 12-bit modular offsets: a pixel left of / above the square wraps to a
  // large value, so markers near the top-left edge clip instead of wrapping.
  function automatic logic marker_hit(input logic [10:0] h, input logic [10:0] v,
                                      input logic [10:0] mx, input logic [10:0] my);
    logic [11:0] dx;
    logic [11:0] dy;
    dx = {1'b0, h} + 12'(MARK / 2) - {1'b0, mx};
    dy = {1'b0, v} + 12'(MARK / 2) - {1'b0, my};
    return (dx < 12'(MARK)) && (dy < 12'(MARK));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with sync and visible-area decode.
// frame_start is registered so it lines up with the registered pixel outputs.
module vga_timing
  import maze_pkg::*;
#(
  parameter int HACT  = H_ACTIVE,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VACT  = V_ACTIVE,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int HT = HACT + HFP + HSYNC + HBP;
  localparam int VT = VACT + VFP + VSYNC + VBP;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (hc == 11'd0) && (vc == 11'(VACT));
      if (hc == 11'(HT - 1)) begin
        hc <= '0;
        vc <= (vc == 11'(VT - 1)) ? 11'd0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
      end
    end
  end

  assign visible = (hc < 11'(HACT)) && (vc < 11'(VACT));
  assign hsync   = (hc >= 11'(HACT + HFP)) && (hc < 11'(HACT + HFP + HSYNC));
  assign vsync   = (vc >= 11'(VACT + VFP)) && (vc < 11'(VACT + VFP + VSYNC));

endmodule

// File: rtl/maze_raster.sv
// Raster scan-out: requests map lines one ahead, buffers and serialises them,
// overlays player/ant markers and registers the VGA pins.
module maze_raster
  import maze_pkg::*;
#(
  parameter int HACT  = H_ACTIVE,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VACT  = V_ACTIVE,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic                clk,
  input  logic                reset,
  output logic [8:0]          row,
  input  logic [2*HACT-1:0]   data,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  input  logic [10:0]         ant1X,
  input  logic [10:0]         ant1Y,
  input  logic [10:0]         ant2X,
  input  logic [10:0]         ant2Y,
  input  logic                win,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                frame_start
);

  localparam int HT = HACT + HFP + HSYNC + HBP;
  localparam int VT = VACT + VFP + VSYNC + VBP;
  localparam int LW = 2 * HACT;

  logic [10:0]   hc;
  logic [10:0]   vc;
  logic          visible;
  logic          hsync;
  logic          vsync;
  logic [LW-1:0] line_buf;
  logic          next_in_frame;
  logic          next_visible;
  logic          capture;
  logic          hit_player;
  logic          hit_ant1;
  logic          hit_ant2;
  logic [23:0]   pix_col;

  vga_timing #(
    .HACT (HACT), .HFP (HFP), .HSYNC (HSYNC), .HBP (HBP),
    .VACT (VACT), .VFP (VFP), .VSYNC (VSYNC), .VBP (VBP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .hc          (hc),
    .vc          (vc),
    .visible     (visible),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // vc+1 < VACT, written without the +1 to stay in 11 bits.
  assign next_in_frame = (vc < 11'(VACT - 1));
  assign next_visible  = next_in_frame || (vc == 11'(VT - 1));
  assign capture       = (hc == 11'(HT - 1)) && next_visible;

  // Row only moves at hc==0, so it is stable for HT-1 cycles before capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row <= '0;
    end else if (hc == 11'd0) begin
      row <= next_in_frame ? 9'(vc + 11'd1) : 9'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_buf <= '0;
    end else if (capture) begin
      line_buf <= data;
    end else if (visible) begin
      line_buf <= {line_buf[LW-3:0], 2'b00};
    end
  end

  assign hit_player = marker_hit(hc, vc, x, y);
  assign hit_ant1   = marker_hit(hc, vc, ant1X, ant1Y);
  assign hit_ant2   = marker_hit(hc, vc, ant2X, ant2Y);

  always_comb begin
    pix_col = COL_BLANK;
    if (visible) begin
      if (hit_player)                pix_col = COL_PLAYER;
      else if (hit_ant1)             pix_col = COL_ANT1;
      else if (hit_ant2)             pix_col = COL_ANT2;
      else if (|line_buf[LW-1 -: 2]) pix_col = COL_WALL;
      else if (win)                  pix_col = COL_WIN;
      else                           pix_col = COL_FLOOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      VGA_BLANK_N <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= pix_col;
      VGA_HS                <= hsync;
      VGA_VS                <= vsync;
      VGA_BLANK_N           <= visible;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_maze_raster.sv
// Scoreboard bench for maze_raster on a reduced 128x64 raster so several
// frames fit in a short run; expected pixels are hand-derived per position.
module tb_maze_raster;

  localparam int HA = 128, HF = 16, HSW = 32, HB = 16;
  localparam int VA = 64,  VF = 6,  VSW = 8,  VB = 4;
  localparam int HT = HA + HF + HSW + HB;   // 192
  localparam int VT = VA + VF + VSW + VB;   // 82
  localparam int FR = HT * VT;              // 15744
  localparam int LW = 2 * HA;

  localparam logic [23:0] BLK = 24'h000000, BLU = 24'h0000FF, WHT = 24'hFFFFFF;
  localparam logic [23:0] GRN = 24'h00FF00, RED = 24'hFF0000, ORG = 24'hFF8000;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    row;
  logic [LW-1:0] data;
  logic [10:0]   x, y, ant1X, ant1Y, ant2X, ant2Y;
  logic          win;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;

  logic [LW-1:0] alt_line;
  logic [LW-1:0] row0_line;

  maze_raster #(
    .HACT (HA), .HFP (HF), .HSYNC (HSW), .HBP (HB),
    .VACT (VA), .VFP (VF), .VSYNC (VSW), .VBP (VB)
  ) dut (
    .clk (clk), .reset (reset), .row (row), .data (data),
    .x (x), .y (y), .ant1X (ant1X), .ant1Y (ant1Y), .ant2X (ant2X), .ant2Y (ant2Y),
    .win (win), .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
    .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N), .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Map generator stand-in: line 5 alternates wall/floor, line 0 has one wall at pixel 10.
  assign data = (row == 9'd5) ? alt_line : (row == 9'd0) ? row0_line : '0;

  typedef struct {
    int          seg;
    int          pos;
    logic [23:0] rgb;
    logic        hs, vs, blank, fs;
    logic [8:0]  row;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   seg = 0;
  int   pos = -1;
  bit   running = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  function automatic int at(input int fr, input int h, input int v);
    return fr * FR + v * HT + h;
  endfunction

  task automatic add(input int s, input int p, input logic [23:0] rgb, input logic hs,
                     input logic vs, input logic blank, input logic fs, input int r,
                     input string name);
    exp_t e;
    e.seg = s; e.pos = p; e.rgb = rgb; e.hs = hs; e.vs = vs;
    e.blank = blank; e.fs = fs; e.row = 9'(r); e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: tracks which counter position each registered output belongs to.
  always @(posedge clk) begin
    logic        rs;
    logic [38:0] act, req;
    rs = reset;
    #1;
    if (!rs) begin
      if (running) seg++;
      running = 1'b0;
      pos = -1;
    end else begin
      running = 1'b1;
      pos++;
    end
    while (sb.size() > 0 && (sb[0].seg < seg || (sb[0].seg == seg && sb[0].pos < pos))) begin
      checks++;
      errors++;
      $display("FAIL %s: position seg %0d pos %0d never observed (now seg %0d pos %0d)",
               sb[0].name, sb[0].seg, sb[0].pos, seg, pos);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].seg == seg && sb[0].pos == pos) begin
      mon_e = sb.pop_front();
      act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, VGA_SYNC_N, row};
      req = {mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.blank, mon_e.fs, 1'b0, mon_e.row};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got rgb=%06h hs=%b vs=%b blank_n=%b fs=%b sync_n=%b row=%0d, want rgb=%06h hs=%b vs=%b blank_n=%b fs=%b sync_n=0 row=%0d",
                 mon_e.name, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
                 VGA_SYNC_N, row, mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.blank, mon_e.fs, mon_e.row);
      end
    end
  end

  task automatic wait_pos(input int s, input int p, input string name);
    int n = 0;
    while (!(seg == s && pos == p) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (!(seg == s && pos == p)) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for seg %0d pos %0d (at seg %0d pos %0d)", name, s, p, seg, pos);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_start_wait: no pulse seen, got %b want 1", frame_start);
    end
  endtask

  initial begin
    reset = 1'b0;
    win   = 1'b0;
    x = 11'd2000; y = 11'd2000;
    ant1X = 11'd2000; ant1Y = 11'd2000;
    ant2X = 11'd2000; ant2Y = 11'd2000;
    alt_line  = '0;
    row0_line = '0;
    for (int p = 0; p < HA; p += 2) alt_line[LW-1-2*p -: 2] = 2'b01;
    row0_line[LW-1-20 -: 2] = 2'b10;

    add(0, -1, BLK, 0, 0, 0, 0, 0, "reset_outputs");
    repeat (3) @(negedge clk);

    // Frame 0: cleared line 0, wall pattern on line 5, sync windows.
    add(0, at(0,   0,  0), BLK, 0, 0, 1, 0, 1, "f0_px0_0");
    add(0, at(0,  10,  0), BLK, 0, 0, 1, 0, 1, "f0_line0_cleared");
    add(0, at(0,   0,  5), BLU, 0, 0, 1, 0, 6, "alt_px0");
    add(0, at(0,   1,  5), BLK, 0, 0, 1, 0, 6, "alt_px1");
    add(0, at(0,   2,  5), BLU, 0, 0, 1, 0, 6, "alt_px2");
    add(0, at(0, 126,  5), BLU, 0, 0, 1, 0, 6, "alt_px126");
    add(0, at(0, 127,  5), BLK, 0, 0, 1, 0, 6, "alt_px127");
    add(0, at(0, 128,  5), BLK, 0, 0, 0, 0, 6, "h_blank_start");
    add(0, at(0, 143,  5), BLK, 0, 0, 0, 0, 6, "hs_before");
    add(0, at(0, 144,  5), BLK, 1, 0, 0, 0, 6, "hs_first");
    add(0, at(0, 175,  5), BLK, 1, 0, 0, 0, 6, "hs_last");
    add(0, at(0, 176,  5), BLK, 0, 0, 0, 0, 6, "hs_after");
    add(0, at(0,   0,  6), BLK, 0, 0, 1, 0, 7, "line6_floor");
    add(0, at(0,   0, 63), BLK, 0, 0, 1, 0, 0, "last_line_row0");
    add(0, at(0,   0, 64), BLK, 0, 0, 0, 1, 0, "frame_start_pulse");
    add(0, at(0,   1, 64), BLK, 0, 0, 0, 0, 0, "frame_start_end");
    add(0, at(0, 191, 69), BLK, 0, 0, 0, 0, 0, "vs_before");
    add(0, at(0,   0, 70), BLK, 0, 1, 0, 0, 0, "vs_first");
    add(0, at(0,   0, 77), BLK, 0, 1, 0, 0, 0, "vs_last");
    add(0, at(0,   0, 78), BLK, 0, 0, 0, 0, 0, "vs_after");
    reset = 1'b1;

    wait_fs();
    x = 11'd100; y = 11'd50;
    ant1X = 11'd102; ant1Y = 11'd52;
    ant2X = 11'd2;   ant2Y = 11'd2;

    // Frame 1: prefetched line 0, markers, clipping, win mid-line.
    add(0, at(1,   0,  0), ORG, 0, 0, 1, 0, 1,  "ant2_0_0");
    add(0, at(1,   5,  0), ORG, 0, 0, 1, 0, 1,  "ant2_5_0");
    add(0, at(1,   6,  0), BLK, 0, 0, 1, 0, 1,  "ant2_right_edge");
    add(0, at(1,  10,  0), BLU, 0, 0, 1, 0, 1,  "line0_prefetched");
    add(0, at(1, 190,  1), BLK, 0, 0, 0, 0, 2,  "no_wrap_hblank");
    add(0, at(1,   5,  5), ORG, 0, 0, 1, 0, 6,  "ant2_5_5");
    add(0, at(1,   6,  5), BLU, 0, 0, 1, 0, 6,  "wall_beside_ant2");
    add(0, at(1,   0,  6), BLK, 0, 0, 1, 0, 7,  "ant2_bottom_edge");
    add(0, at(1,  95, 47), BLK, 0, 0, 1, 0, 48, "player_left_out");
    add(0, at(1,  96, 47), GRN, 0, 0, 1, 0, 48, "player_left_in");
    add(0, at(1,  97, 47), GRN, 0, 0, 1, 0, 48, "player_97_47");
    add(0, at(1, 103, 50), GRN, 0, 0, 1, 0, 51, "player_over_ant1");
    add(0, at(1, 104, 50), RED, 0, 0, 1, 0, 51, "ant1_104_50");
    add(0, at(1, 105, 55), RED, 0, 0, 1, 0, 56, "ant1_105_55");
    add(0, at(1, 106, 55), BLK, 0, 0, 1, 0, 56, "ant1_right_out");
    add(0, at(1, 103, 56), BLK, 0, 0, 1, 0, 57, "ant1_bottom_out");
    add(0, at(1,  20, 60), BLK, 0, 0, 1, 0, 61, "win_before");
    add(0, at(1,  21, 60), WHT, 0, 0, 1, 0, 61, "win_next_pixel");
    add(0, at(1, 100, 60), WHT, 0, 0, 1, 0, 61, "win_floor");
    add(0, at(1, 130, 60), BLK, 0, 0, 0, 0, 61, "win_blank_black");
    add(0, at(2,   0,  0), ORG, 0, 0, 1, 0, 1,  "f2_ant2");
    add(0, at(2,  10,  0), BLU, 0, 0, 1, 0, 1,  "f2_wall_over_win");
    add(0, at(2,  11,  0), WHT, 0, 0, 1, 0, 1,  "f2_win_floor");

    wait_pos(0, at(1, 20, 60), "win_set");
    win = 1'b1;

    wait_pos(0, at(2, 50, 20), "mid_reset");
    add(1, -1, BLK, 0, 0, 0, 0, 0, "mid_reset_outputs");
    add(1,  0, ORG, 0, 0, 1, 0, 1, "restart_px0_0");
    add(1, 10, WHT, 0, 0, 1, 0, 1, "restart_buf_cleared");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 5000 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
